// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS sequencing controller:
// FSM states, opcode/funct values, ALU and next-PC selects, decode result.
package mips_pkg;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_WB,
        S_HALT,
        S_FAULT
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_BLT   = 6'h06;
    localparam logic [5:0] OP_BGT   = 6'h07;
    localparam logic [5:0] OP_ADDI  = 6'h08;

    localparam logic [5:0] FUNCT_ADD = 6'h20;
    localparam logic [5:0] FUNCT_SUB = 6'h22;
    localparam logic [5:0] FUNCT_AND = 6'h24;
    localparam logic [5:0] FUNCT_SLT = 6'h2A;
    localparam logic [5:0] FUNCT_JR  = 6'h08;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_SLT = 2'b11;

    localparam logic [1:0] PC_SEL_SEQ    = 2'd0;
    localparam logic [1:0] PC_SEL_REG    = 2'd1;
    localparam logic [1:0] PC_SEL_JUMP   = 2'd2;
    localparam logic [1:0] PC_SEL_BRANCH = 2'd3;

    typedef enum logic [2:0] {
        CLS_ALU,
        CLS_ADDI,
        CLS_BRANCH,
        CLS_J,
        CLS_JR,
        CLS_ILLEGAL
    } iclass_t;

    typedef struct packed {
        iclass_t    cls;
        logic [1:0] alu_op;
        logic       alu_src;
        logic       illegal;
    } dec_t;

    // Flags come from a - b; a signed overflow in that subtract is not corrected.
    function automatic logic branch_taken(input logic [5:0] op, input logic zero, input logic neg);
        case (op)
            OP_BEQ:  return zero;
            OP_BNE:  return !zero;
            OP_BLT:  return neg;
            OP_BGT:  return !neg && !zero;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mips_decode.sv
// Combinational opcode/funct decoder: instruction class plus the ALU
// controls that the class drives during EXEC and WB.
module mips_decode
    import mips_pkg::*;
(
    input  logic [5:0] op,
    input  logic [5:0] funct,
    output dec_t       dec
);

    always_comb begin
        dec = '{cls: CLS_ILLEGAL, alu_op: ALU_ADD, alu_src: 1'b0, illegal: 1'b1};
        case (op)
            OP_RTYPE: begin
                case (funct)
                    FUNCT_ADD: dec = '{cls: CLS_ALU, alu_op: ALU_ADD, alu_src: 1'b0, illegal: 1'b0};
                    FUNCT_SUB: dec = '{cls: CLS_ALU, alu_op: ALU_SUB, alu_src: 1'b0, illegal: 1'b0};
                    FUNCT_AND: dec = '{cls: CLS_ALU, alu_op: ALU_AND, alu_src: 1'b0, illegal: 1'b0};
                    FUNCT_SLT: dec = '{cls: CLS_ALU, alu_op: ALU_SLT, alu_src: 1'b0, illegal: 1'b0};
                    FUNCT_JR:  dec = '{cls: CLS_JR,  alu_op: ALU_ADD, alu_src: 1'b0, illegal: 1'b0};
                    default:   ;
                endcase
            end
            OP_ADDI: dec = '{cls: CLS_ADDI, alu_op: ALU_ADD, alu_src: 1'b1, illegal: 1'b0};
            OP_BEQ, OP_BNE, OP_BLT, OP_BGT:
                     dec = '{cls: CLS_BRANCH, alu_op: ALU_SUB, alu_src: 1'b0, illegal: 1'b0};
            OP_J:    dec = '{cls: CLS_J, alu_op: ALU_ADD, alu_src: 1'b0, illegal: 1'b0};
            default: ;
        endcase
    end

endmodule

// File: rtl/mips_seq_ctrl.sv
// Multicycle sequencer: FETCH over req/ack, then DECODE/EXEC/WB, with halt,
// fetch-timeout fault and a retired-instruction counter.
module mips_seq_ctrl
    import mips_pkg::*;
#(
    parameter int FETCH_TIMEOUT = 16,
    parameter int CNT_W         = 32
) (
    input  logic             clk,
    input  logic             reset,
    output logic             imem_req,
    input  logic             imem_ack,
    input  logic [31:0]      imem_rdata,
    input  logic             halt_req,
    input  logic             alu_zero,
    input  logic             alu_neg,
    output logic             ir_load,
    output logic             alu_src,
    output logic [1:0]       alu_op,
    output logic             reg_write,
    output logic             wr_sel_rt,
    output logic             pc_write,
    output logic [1:0]       pc_sel,
    output logic             illegal_op,
    output logic             halted,
    output logic             fault,
    output logic [CNT_W-1:0] retired_cnt
);

    localparam int TW = (FETCH_TIMEOUT > 1) ? $clog2(FETCH_TIMEOUT) : 1;

    state_t        state;
    logic [31:0]   ir;
    logic [TW-1:0] wait_cnt;
    dec_t          dec;
    logic          fetch_done;
    logic          timeout;
    logic          unused_ir;

    mips_decode u_decode (
        .op    (ir[31:26]),
        .funct (ir[5:0]),
        .dec   (dec)
    );

    assign unused_ir  = ^ir[25:6];
    assign fetch_done = (state == S_FETCH) && imem_req && imem_ack;
    assign timeout    = (FETCH_TIMEOUT != 0) && (state == S_FETCH) && imem_req && !imem_ack
                        && (wait_cnt == TW'(FETCH_TIMEOUT - 1));

    // Strobes are decoded from state so that each lands in exactly one cycle.
    always_comb begin
        ir_load    = fetch_done;
        reg_write  = 1'b0;
        wr_sel_rt  = 1'b0;
        pc_write   = 1'b0;
        pc_sel     = PC_SEL_SEQ;
        illegal_op = 1'b0;
        case (state)
            S_DECODE: begin
                case (dec.cls)
                    CLS_J:       begin pc_write = 1'b1; pc_sel = PC_SEL_JUMP; end
                    CLS_JR:      begin pc_write = 1'b1; pc_sel = PC_SEL_REG;  end
                    CLS_ILLEGAL: begin pc_write = 1'b1; illegal_op = 1'b1;    end
                    default:     ;
                endcase
            end
            S_WB: begin
                pc_write = 1'b1;
                if (dec.cls == CLS_BRANCH) begin
                    pc_sel = branch_taken(ir[31:26], alu_zero, alu_neg) ? PC_SEL_BRANCH : PC_SEL_SEQ;
                end else begin
                    reg_write = 1'b1;
                    wr_sel_rt = (dec.cls == CLS_ADDI);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= S_FETCH;
            ir          <= '0;
            wait_cnt    <= '0;
            imem_req    <= 1'b0;
            halted      <= 1'b0;
            fault       <= 1'b0;
            alu_src     <= 1'b0;
            alu_op      <= ALU_ADD;
            retired_cnt <= '0;
        end else begin
            case (state)
                S_FETCH: begin
                    imem_req <= 1'b1;
                    if (fetch_done) begin
                        ir       <= imem_rdata;
                        wait_cnt <= '0;
                        imem_req <= 1'b0;
                        state    <= S_DECODE;
                    end else if (timeout) begin
                        wait_cnt <= '0;
                        imem_req <= 1'b0;
                        fault    <= 1'b1;
                        state    <= S_FAULT;
                    end else if (imem_req) begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                S_DECODE: begin
                    if (!pc_write) begin
                        alu_src <= dec.alu_src;
                        alu_op  <= dec.alu_op;
                        state   <= S_EXEC;
                    end
                end
                S_EXEC: state <= S_WB;
                S_WB: begin
                    alu_src <= 1'b0;
                    alu_op  <= ALU_ADD;
                end
                S_HALT: begin
                    if (!halt_req) begin
                        halted   <= 1'b0;
                        imem_req <= 1'b1;
                        state    <= S_FETCH;
                    end
                end
                S_FAULT: ;
                default: state <= S_FETCH;
            endcase

            // Instruction boundary: the only place halt_req is honoured.
            if (pc_write) begin
                retired_cnt <= retired_cnt + 1'b1;
                if (halt_req) begin
                    halted <= 1'b1;
                    state  <= S_HALT;
                end else begin
                    imem_req <= 1'b1;
                    state    <= S_FETCH;
                end
            end
        end
    end

endmodule

// File: doc/mips_seq_ctrl.md
Name: mips_seq_ctrl

Overview:
- Multicycle sequencing controller for the non-pipelined MIPS datapath. Replaces the two-state IDLE/EXECUTE controller.
- Fetches each instruction over a req/ack handshake with instruction memory and latches it into the datapath instruction register.
- Then steps the datapath through DECODE/EXEC/WB, drives the ALU and register-file controls, and selects the next PC.
- Adds halt, fetch-timeout fault, illegal-opcode flagging and a retired-instruction counter.

Parameters:
FETCH_TIMEOUT, 16, max FETCH cycles waiting for imem_ack before FAULT; 0 disables the timeout
CNT_W, 32, width of retired_cnt

Ports:
clk  in  1  single clock, all state on rising edge
reset  in  1  synchronous, active-low reset (asserted when 0)
imem_req  out  1  instruction fetch request
imem_ack  in  1  fetch complete; imem_rdata valid this cycle
imem_rdata  in  32  fetched instruction
halt_req  in  1  request to stop at the next instruction boundary
alu_zero  in  1  datapath ALU result == 0 (registered result from EXEC)
alu_neg  in  1  datapath ALU result[31]
ir_load  out  1  load imem_rdata into datapath IR
alu_src  out  1  0 = rt register, 1 = sign-extended immediate
alu_op  out  2  00 ADD, 01 SUB, 10 AND, 11 SLT
reg_write  out  1  write ALU result to rd (R-type) / rt (ADDI)
wr_sel_rt  out  1  1 = destination is rt (ADDI)
pc_write  out  1  update PC this cycle
pc_sel  out  2  0 PC+4, 1 reg[rs] (JR), 2 jump target, 3 PC+4+(sext(imm)<<2)
illegal_op  out  1  one-cycle pulse on unsupported opcode/funct
halted  out  1  controller in HALT
fault  out  1  sticky fetch-timeout fault
retired_cnt  out  CNT_W  instructions retired since reset, wraps

Behaviour:
- States: FETCH, DECODE, EXEC, WB, HALT, FAULT. The IR copy is held internally and decoded from DECODE onward.
- Reset (reset==0 at an edge) returns to FETCH from any state, including mid-fetch or mid-WB.
  - All outputs go to 0: imem_req dropped, fault cleared, retired_cnt=0.
  - alu_op=00, pc_sel=00.
- FETCH:
  - imem_req=1.
  - On imem_req&&imem_ack: ir_load=1, internal IR<=imem_rdata, next state DECODE.
  - Wait counter increments each FETCH cycle without ack. When it reaches FETCH_TIMEOUT-1 with no ack, go to FAULT.
  - The counter clears on leaving FETCH.
- DECODE (one cycle):
  - J: pc_write=1, pc_sel=2, retire, go to FETCH/HALT.
  - JR (op 000000, funct 001000): pc_write=1, pc_sel=1, retire.
  - Illegal: illegal_op=1, pc_write=1, pc_sel=0, retire (executes as a NOP).
  - All others go to EXEC.
- EXEC:
  - alu_src/alu_op are driven for the class: R-type per funct, ADDI src=1 op=00, all branches src=0 op=01 (SUB).
  - Datapath registers the ALU result at the end of EXEC.
  - Branches skip WB and resolve in the following cycle from alu_zero/alu_neg, which is the first cycle WB would occupy. Take no branch decision from flags in EXEC itself.
  - Implementation: EXEC→WB for every class, and branch-class WB does the branch resolution.
- WB:
  - alu_src/alu_op are held at their EXEC values.
  - R-type/ADDI: reg_write=1, wr_sel_rt=(ADDI), pc_write=1, pc_sel=0.
  - BEQ taken iff alu_zero.
  - BNE taken iff !alu_zero.
  - BLT taken iff alu_neg.
  - BGT taken iff !alu_neg&&!alu_zero.
  - Taken: pc_sel=3. Not taken: pc_sel=0. pc_write=1 either way.
  - Signed overflow in the branch compare is ignored.
- Retire: exactly one pc_write pulse per instruction, and retired_cnt+=1 in that same cycle, wrapping at 2^CNT_W.
  - On retire, next state = HALT if halt_req==1, else FETCH.
- HALT: halted=1, imem_req=0. Exit to FETCH when halt_req==0. halt_req never interrupts an instruction in progress.
- FAULT: fault=1, all strobes 0. Left only by reset.
- Cycle counts with ack in the first FETCH cycle: J/JR/illegal 2, branch 4, R-type/ADDI 4.
- Control strobes (ir_load, reg_write, pc_write, illegal_op) are single-cycle and never overlap across instructions.

Decomposition:
- Package mips_pkg: state_t enum; OP_RTYPE/ADDI/BEQ/BNE/BLT/BGT/J and FUNCT_ADD/SUB/AND/SLT/JR constants; ALU_ADD/SUB/AND/SLT and PC_SEL_* encodings; instruction-class enum.
- One combinational sub-module, mips_decode, maps opcode/funct to {class, alu_op, alu_src, illegal}. mips_seq_ctrl holds the FSM, timeout counter and retired counter.

Test Plan:
- Reset held 0 for 3 cycles during FETCH with imem_ack=0 → imem_req=0, retired_cnt=0. After release, imem_req=1 next cycle.
- ADD (0x00221820), ack immediate → ir_load at cycle 0; alu_op=00, src=0 in EXEC/WB; reg_write & pc_write(sel 0) at cycle 3; retired_cnt=1.
- BEQ then BGT:
  - BEQ with alu_zero=1 in WB → pc_sel=3.
  - BGT with alu_zero=0, alu_neg=1 → pc_sel=0, not taken.
  - Both have reg_write=0.
- J 0x08000010 → pc_write with pc_sel=2 in DECODE, 2 cycles total. JR → pc_sel=1.
- Illegal opcode 0x3F → illegal_op pulse in DECODE, pc_sel=0, retired_cnt increments.
- Fetch timeout and halt:
  - imem_ack held 0 with FETCH_TIMEOUT=16 → FAULT after 16 FETCH cycles, fault=1 sticky until reset.
  - halt_req=1 during ADD EXEC → ADD completes, then HALT, halted=1. Deassert → FETCH.
